jam_search: RTL



---
 rtl/jam_search_pkg.sv | 24 ++
 rtl/jam_search_if.sv | 29 ++
 rtl/jam_search_next_perm.sv | 33 +++
 rtl/jam_search.sv | 104 ++++++++++
 4 files changed

// File: rtl/jam_search_pkg.sv
// Shared types for the exhaustive assignment search: permutation storage sized for the largest N,
// FSM state encoding and the identity permutation used on every (re)start.
package jam_pkg;

  localparam int MAX_N  = 8;
  localparam int MAX_IW = 3;

  typedef logic [MAX_IW-1:0] idx_t;
  typedef idx_t [MAX_N-1:0]  perm_t;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_SEARCH = 2'd1,
    S_FLUSH  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  function automatic perm_t identity_perm();
    perm_t p;
    for (int k = 0; k < MAX_N; k++) p[k] = idx_t'(k);
    return p;
  endfunction

endpackage

// File: rtl/jam_search_if.sv
// Host-side bundle of the search engine: matrix load indices/cost, re-run request and results.
// The engine drives through 'master'; the host answers Cost combinationally through 'slave'.
interface jam_search_if #(
  parameter int N   = 8,
  parameter int CW  = 7,
  parameter int MCW = 16
) ();
  localparam int IW = $clog2(N);
  localparam int SW = CW + IW;

  logic            Start;
  logic [IW-1:0]   W;
  logic [IW-1:0]   J;
  logic [CW-1:0]   Cost;
  logic [SW-1:0]   MinCost;
  logic [MCW-1:0]  MatchCount;
  logic [N*IW-1:0] BestPerm;
  logic            Valid;

  modport master (
    input  Start, Cost,
    output W, J, MinCost, MatchCount, BestPerm, Valid
  );

  modport slave (
    output Start, Cost,
    input  W, J, MinCost, MatchCount, BestPerm, Valid
  );
endinterface

// File: rtl/jam_search_next_perm.sv
// Combinational lexicographic successor of the first N entries of a permutation; zero latency.
// 'last' flags a strictly descending input, for which perm_nxt carries no meaning.
module jam_next_perm import jam_pkg::*; #(
  parameter int N = 8
) (
  input  perm_t perm,
  output perm_t perm_nxt,
  output logic  last
);
  perm_t swp;
  int    piv;
  int    sel;

  always_comb begin
    last = 1'b1;
    piv  = 0;
    sel  = 0;
    for (int i = 0; i < N-1; i++)
      if (perm[i] < perm[i+1]) begin
        piv  = i;
        last = 1'b0;
      end
    for (int j = 0; j < N; j++)
      if (j > piv && perm[j] > perm[piv]) sel = j;
    swp      = perm;
    swp[piv] = perm[sel];
    swp[sel] = perm[piv];
    perm_nxt = swp;
    // Tail after the pivot is descending, so reversing it gives the smallest suffix.
    for (int k = 0; k < N; k++)
      if (k > piv) perm_nxt[k] = swp[N + piv - k];
  end
endmodule

// File: rtl/jam_search.sv
// Loads an NxN cost matrix, then scores one permutation per cycle through a 2-stage sum/compare pipe.
// Results valid N*N + N! + 2 cycles after reset or Start; no backpressure, Cost must answer same cycle.
module jam_search import jam_pkg::*; #(
  parameter int N   = 8,
  parameter int CW  = 7,
  parameter int MCW = 16
) (
  input logic          CLK,
  input logic          RST,
  jam_search_if.master bus
);
  localparam int IW = $clog2(N);
  localparam int SW = CW + IW;

  state_t         state, state_nxt;
  logic [CW-1:0]  matrix [N][N];
  logic [IW-1:0]  w, j;
  perm_t          perm, perm_nxt, s1_perm, best;
  logic           perm_last, perm_end, s1_vld, clear;
  logic [SW-1:0]  sum, s1_sum, min_cost;
  logic [MCW-1:0] match_cnt;

  jam_next_perm #(.N(N)) u_next_perm (
    .perm     (perm),
    .perm_nxt (perm_nxt),
    .last     (perm_last)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= S_LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:   if (w == IW'(N-1) && j == IW'(N-1)) state_nxt = S_SEARCH;
      S_SEARCH: if (perm_end) state_nxt = S_FLUSH;
      S_FLUSH:  state_nxt = S_DONE;
      S_DONE:   if (bus.Start) state_nxt = S_LOAD;
      default:  state_nxt = S_LOAD;
    endcase
  end

  assign clear = RST || (state == S_DONE && bus.Start);

  always_comb begin
    sum = '0;
    for (int k = 0; k < N; k++) sum = sum + SW'(matrix[k][perm[k][IW-1:0]]);
  end

  always_ff @(posedge CLK) begin
    if (state == S_LOAD && !RST) matrix[w][j] <= bus.Cost;
  end

  always_ff @(posedge CLK) begin
    s1_sum  <= sum;
    s1_perm <= perm;
    if (clear) begin
      w         <= '0;
      j         <= '0;
      perm      <= identity_perm();
      perm_end  <= 1'b0;
      s1_vld    <= 1'b0;
      min_cost  <= '1;
      match_cnt <= '0;
      best      <= identity_perm();
    end else begin
      // perm_end holds the last permutation for one extra cycle so stage 1 scores it exactly once.
      s1_vld <= (state == S_SEARCH) && !perm_end;
      if (state == S_LOAD) begin
        if (j == IW'(N-1)) begin
          j <= '0;
          w <= (w == IW'(N-1)) ? '0 : w + 1'b1;
        end else begin
          j <= j + 1'b1;
        end
      end
      if (state == S_SEARCH && !perm_end) begin
        if (perm_last) perm_end <= 1'b1;
        else           perm     <= perm_nxt;
      end
      if (s1_vld) begin
        if (s1_sum < min_cost) begin
          min_cost  <= s1_sum;
          match_cnt <= MCW'(1);
          best      <= s1_perm;
        end else if (s1_sum == min_cost && match_cnt != '1) begin
          match_cnt <= match_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.W          = w;
  assign bus.J          = j;
  assign bus.MinCost    = min_cost;
  assign bus.MatchCount = match_cnt;
  assign bus.Valid      = (state == S_DONE);

  for (genvar k = 0; k < N; k++) begin : g_best
    assign bus.BestPerm[k*IW +: IW] = best[k][IW-1:0];
  end
endmodule
